// File: rtl/spike_gen_pkg.sv
// Shared types and constants for the time-multiplexed spike generator scheduler.
package spike_gen_pkg;

  localparam int NGENS    = 8;
  localparam int NPERIOD  = 16;
  localparam int NTAG     = 11;
  localparam int NCT      = 9;
  localparam int NENTRIES = 1 << NGENS;

  localparam logic [NCT-1:0] CT_PLUS  = 9'h001;
  localparam logic [NCT-1:0] CT_MINUS = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    EMIT
  } sched_state_e;

  typedef struct packed {
    logic [NPERIOD-1:0] period;
    logic [NPERIOD-1:0] ticks;
    logic [NTAG-1:0]    tag;
    logic               sign;
  } gen_entry_t;

  function automatic logic [NCT-1:0] sign_to_ct(input logic sign);
    return sign ? CT_MINUS : CT_PLUS;
  endfunction

endpackage

// File: rtl/spike_gen_state_mem.sv
// Per-generator state memory: combinational read, synchronous write, no reset
// (software programs every generator before enabling it).
module spike_gen_state_mem
  import spike_gen_pkg::*;
(
  input  logic             clk,
  input  logic [NGENS-1:0] rd_addr,
  output gen_entry_t       rd_data,
  input  logic             wr_en,
  input  logic [NGENS-1:0] wr_addr,
  input  gen_entry_t       wr_data
);

  gen_entry_t mem_q [NENTRIES];

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/spike_gen_scheduler.sv
// Sweeps generators 0..gens_used once per time unit, decrementing countdowns and
// emitting one tag/count word per expiring enabled generator; programs entries between sweeps.
module spike_gen_scheduler
  import spike_gen_pkg::*;
#(
  parameter int Ngens   = NGENS,
  parameter int Nperiod = NPERIOD,
  parameter int Ntag    = NTAG,
  parameter int Nct     = NCT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [Ngens-1:0]        gens_used,
  input  logic [(1<<Ngens)-1:0]   gens_en,
  input  logic                    time_unit_pulse,
  input  logic [Ngens-1:0]        prog_gen_idx,
  input  logic [Nperiod-1:0]      prog_period,
  input  logic [Nperiod-1:0]      prog_ticks,
  input  logic [Ntag-1:0]         prog_tag,
  input  logic                    prog_sign,
  input  logic                    prog_v,
  output logic                    prog_a,
  output logic [Ntag-1:0]         out_tag,
  output logic [Nct-1:0]          out_ct,
  output logic                    out_v,
  input  logic                    out_a,
  output logic                    busy,
  output logic                    overrun
);

  sched_state_e     state_q, state_d;
  logic [Ngens-1:0] idx_q, idx_d;
  logic             tick_pending_q, tick_pending_d;
  logic             overrun_q, overrun_d;
  logic             prog_hold_q;
  logic [Ntag-1:0]  out_tag_q, out_tag_d;
  logic [Nct-1:0]   out_ct_q, out_ct_d;

  gen_entry_t       rd_entry, wr_entry;
  logic             wr_en;
  logic [Ngens-1:0] wr_addr;

  logic tick_req, start_sweep, entry_active, last_idx, prog_accept, emit;

  spike_gen_state_mem u_mem (
    .clk     (clk),
    .rd_addr (idx_q),
    .rd_data (rd_entry),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_entry)
  );

  // A pulse arriving in IDLE starts the sweep the very next cycle without waiting on tick_pending.
  assign tick_req     = tick_pending_q | time_unit_pulse;
  assign start_sweep  = (state_q == IDLE) && tick_req;
  assign entry_active = gens_en[idx_q] && (rd_entry.period != '0);
  assign last_idx     = (idx_q == gens_used);
  assign prog_accept  = (state_q == IDLE) && !tick_req && prog_v && !prog_hold_q;

  // A pulse that coincides with a sweep start stays pending; the consumed one does not.
  assign tick_pending_d = start_sweep ? (tick_pending_q & time_unit_pulse)
                                      : (tick_pending_q | time_unit_pulse);
  assign overrun_d      = overrun_q | (time_unit_pulse & tick_pending_q & ~start_sweep);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_tag_d = out_tag_q;
    out_ct_d  = out_ct_q;
    wr_en     = 1'b0;
    wr_addr   = idx_q;
    wr_entry  = rd_entry;
    emit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else if (prog_accept) begin
          wr_en           = 1'b1;
          wr_addr         = prog_gen_idx;
          wr_entry.period = prog_period;
          wr_entry.ticks  = prog_ticks;
          wr_entry.tag    = prog_tag;
          wr_entry.sign   = prog_sign;
        end
      end

      SWEEP: begin
        if (entry_active) begin
          wr_en = 1'b1;
          if (rd_entry.ticks == '0) begin
            wr_entry.ticks = rd_entry.period - 1'b1;
            out_tag_d      = rd_entry.tag;
            out_ct_d       = sign_to_ct(rd_entry.sign);
            emit           = 1'b1;
          end else begin
            wr_entry.ticks = rd_entry.ticks - 1'b1;
          end
        end
        if (emit) begin
          state_d = EMIT;
        end else if (last_idx) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      EMIT: begin
        if (out_a) begin
          if (last_idx) begin
            state_d = IDLE;
          end else begin
            state_d = SWEEP;
            idx_d   = idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      prog_hold_q    <= 1'b0;
      out_tag_q      <= '0;
      out_ct_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;
      prog_hold_q    <= prog_accept;
      out_tag_q      <= out_tag_d;
      out_ct_q       <= out_ct_d;
    end
  end

  assign prog_a  = prog_accept;
  assign out_tag = out_tag_q;
  assign out_ct  = out_ct_q;
  assign out_v   = (state_q == EMIT);
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed scenario bench for spike_gen_scheduler; each handshaked output word is logged.
module tb_spike_gen_scheduler;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   gens_used = '0;
  logic [255:0] gens_en = '0;
  logic         time_unit_pulse = 1'b0;
  logic [7:0]   prog_gen_idx = '0;
  logic [15:0]  prog_period = '0;
  logic [15:0]  prog_ticks = '0;
  logic [10:0]  prog_tag = '0;
  logic         prog_sign = 1'b0;
  logic         prog_v = 1'b0;
  logic         prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v;
  logic         out_a = 1'b1;
  logic         busy;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  logic [10:0] log_tag[$];
  logic [8:0]  log_ct[$];

  spike_gen_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .gens_used       (gens_used),
    .gens_en         (gens_en),
    .time_unit_pulse (time_unit_pulse),
    .prog_gen_idx    (prog_gen_idx),
    .prog_period     (prog_period),
    .prog_ticks      (prog_ticks),
    .prog_tag        (prog_tag),
    .prog_sign       (prog_sign),
    .prog_v          (prog_v),
    .prog_a          (prog_a),
    .out_tag         (out_tag),
    .out_ct          (out_ct),
    .out_v           (out_v),
    .out_a           (out_a),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Word transfers at the next rising edge when out_v && out_a are seen here.
  always @(negedge clk) begin
    if (reset_n && out_v && out_a) begin
      log_tag.push_back(out_tag);
      log_ct.push_back(out_ct);
      $display("[%0t] word tag=0x%03h ct=0x%03h", $time, out_tag, out_ct);
    end
  end

  task automatic clear_log();
    log_tag.delete();
    log_ct.delete();
  endtask

  task automatic pulse_once();
    @(posedge clk); #1 time_unit_pulse = 1'b1;
    @(posedge clk); #1 time_unit_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic do_tick(input string name);
    pulse_once();
    wait_idle(name);
  endtask

  task automatic wait_out_v(input string name);
    int n = 0;
    @(negedge clk);
    while (!out_v && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_v) begin
      errors++;
      $display("FAIL %s_outv_timeout: out_v=%0b required 1", name, out_v);
    end
  endtask

  task automatic prog(input logic [7:0] idx, input logic [15:0] per, input logic [15:0] tk,
                      input logic [10:0] tag, input logic sg);
    int n = 0;
    @(posedge clk); #1;
    prog_v = 1'b1; prog_gen_idx = idx; prog_period = per;
    prog_ticks = tk; prog_tag = tag; prog_sign = sg;
    @(negedge clk);
    while (!prog_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!prog_a) begin
      errors++;
      $display("FAIL prog_timeout gen%0d: prog_a=%0b required 1", idx, prog_a);
    end
    @(posedge clk); #1 prog_v = 1'b0;
    $display("[%0t] prog gen%0d period=%0d ticks=%0d tag=0x%03h sign=%0b", $time, idx, per, tk, tag, sg);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_v, busy, overrun, prog_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: out_v/busy/overrun/prog_a=%b required 0000", {out_v, busy, overrun, prog_a});
    end
    checks++;
    if (out_tag !== 11'h000 || out_ct !== 9'h000) begin
      errors++;
      $display("FAIL reset_data: tag=0x%03h ct=0x%03h required 0x000 0x000", out_tag, out_ct);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b out_v=%0b required 0 0", busy, out_v);
    end
  endtask

  task automatic test_period();
    int exp;
    gens_used = 8'd7;
    gens_en = '0;
    prog(8'd3, 16'd4, 16'd0, 11'h155, 1'b0);
    gens_en[3] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      clear_log();
      do_tick("period");
      exp = (t % 4 == 1) ? 1 : 0;
      checks++;
      if (log_tag.size() != exp) begin
        errors++;
        $display("FAIL period_count tu%0d: words=%0d required %0d", t, log_tag.size(), exp);
      end else if (exp == 1) begin
        checks++;
        if (log_tag[0] !== 11'h155 || log_ct[0] !== 9'h001) begin
          errors++;
          $display("FAIL period_word tu%0d: tag=0x%03h ct=0x%03h required 0x155 0x001", t, log_tag[0], log_ct[0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic held;
    int exp;
    gens_en = '0;
    prog(8'd0, 16'd1, 16'd0, 11'h010, 1'b1);
    prog(8'd1, 16'd2, 16'd1, 11'h011, 1'b0);
    gens_en[1:0] = 2'b11;
    gens_used = 8'd1;
    out_a = 1'b0;
    clear_log();
    pulse_once();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_cycle: busy=%0b out_v=%0b required 1 0", busy, out_v);
    end
    @(negedge clk);
    checks++;
    if (out_v !== 1'b1 || out_tag !== 11'h010 || out_ct !== 9'h1FF) begin
      errors++;
      $display("FAIL bp_latency: out_v=%0b tag=0x%03h ct=0x%03h required 1 0x010 0x1FF", out_v, out_tag, out_ct);
    end
    held = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_v === 1'b1 && out_tag === 11'h010 && out_ct === 9'h1FF)) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL bp_hold: out_v=%0b tag=0x%03h ct=0x%03h required held 1 0x010 0x1FF", out_v, out_tag, out_ct);
    end
    @(posedge clk); #1 out_a = 1'b1;
    wait_idle("bp_release");
    checks++;
    if (log_tag.size() != 1) begin
      errors++;
      $display("FAIL bp_tu1_count: words=%0d required 1", log_tag.size());
    end
    for (int t = 2; t <= 5; t++) begin
      clear_log();
      do_tick("bp");
      exp = (t % 2 == 0) ? 2 : 1;
      checks++;
      if (log_tag.size() != exp) begin
        errors++;
        $display("FAIL bp_count tu%0d: words=%0d required %0d", t, log_tag.size(), exp);
      end else begin
        checks++;
        if (log_tag[0] !== 11'h010 || log_ct[0] !== 9'h1FF) begin
          errors++;
          $display("FAIL bp_gen0 tu%0d: tag=0x%03h ct=0x%03h required 0x010 0x1FF", t, log_tag[0], log_ct[0]);
        end
        if (exp == 2) begin
          checks++;
          if (log_tag[1] !== 11'h011 || log_ct[1] !== 9'h001) begin
            errors++;
            $display("FAIL bp_gen1 tu%0d: tag=0x%03h ct=0x%03h required 0x011 0x001", t, log_tag[1], log_ct[1]);
          end
        end
      end
    end
  endtask

  task automatic test_prog_collision();
    int n = 0;
    gens_en = '0;
    gens_en[0] = 1'b1;
    gens_used = 8'd0;
    clear_log();
    @(posedge clk); #1;
    time_unit_pulse = 1'b1;
    prog_v = 1'b1; prog_gen_idx = 8'd0; prog_period = 16'd1;
    prog_ticks = 16'd0; prog_tag = 11'h0AA; prog_sign = 1'b0;
    @(negedge clk);
    checks++;
    if (prog_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_tick_priority: prog_a=%0b required 0", prog_a);
    end
    @(posedge clk); #1 time_unit_pulse = 1'b0;
    @(negedge clk);
    while (!prog_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (prog_a !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_prog_after_sweep: prog_a=%0b busy=%0b required 1 0", prog_a, busy);
    end
    checks++;
    if (log_tag.size() != 1 || log_tag[0] !== 11'h010) begin
      errors++;
      $display("FAIL coll_old_word: words=%0d required 1 with tag 0x010", log_tag.size());
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (prog_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_prog_a_gap: prog_a=%0b required 0", prog_a);
    end
    @(posedge clk); #1 prog_v = 1'b0;
    clear_log();
    do_tick("coll");
    checks++;
    if (log_tag.size() != 1 || log_tag[0] !== 11'h0AA || log_ct[0] !== 9'h001) begin
      errors++;
      $display("FAIL coll_new_word: words=%0d required 1 with tag 0x0AA ct 0x001", log_tag.size());
    end
  endtask

  task automatic test_overrun();
    gens_en = '0;
    gens_en[0] = 1'b1;
    gens_used = 8'd3;
    out_a = 1'b0;
    clear_log();
    pulse_once();
    wait_out_v("ovr");
    pulse_once();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_second_pulse: overrun=%0b required 0", overrun);
    end
    pulse_once();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_third_pulse: overrun=%0b required 1", overrun);
    end
    @(posedge clk); #1 out_a = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (log_tag.size() != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_extra_sweep: words=%0d busy=%0b required 2 0", log_tag.size(), busy);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: overrun=%0b required 1", overrun);
    end
  endtask

  task automatic test_inactive();
    int exp;
    gens_used = 8'd7;
    gens_en = '0;
    gens_en[0] = 1'b1;
    prog(8'd5, 16'd3, 16'd1, 11'h055, 1'b0);
    prog(8'd6, 16'd0, 16'd0, 11'h066, 1'b0);
    gens_en[6] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      clear_log();
      do_tick("inact");
      checks++;
      if (log_tag.size() != 1 || log_tag[0] !== 11'h0AA) begin
        errors++;
        $display("FAIL inact_disabled tu%0d: words=%0d required 1 with tag 0x0AA", t, log_tag.size());
      end
    end
    gens_en[5] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      clear_log();
      do_tick("inact_en");
      exp = (t == 2) ? 2 : 1;
      checks++;
      if (log_tag.size() != exp) begin
        errors++;
        $display("FAIL inact_enabled_count tu%0d: words=%0d required %0d", t, log_tag.size(), exp);
      end else if (exp == 2) begin
        checks++;
        if (log_tag[1] !== 11'h055 || log_ct[1] !== 9'h001) begin
          errors++;
          $display("FAIL inact_gen5_word: tag=0x%03h ct=0x%03h required 0x055 0x001", log_tag[1], log_ct[1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    out_a = 1'b0;
    pulse_once();
    wait_out_v("rst");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_v, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async: out_v/busy/overrun=%b required 000", {out_v, busy, overrun});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_a = 1'b1;
    clear_log();
    do_tick("rst_tu1");
    checks++;
    if (log_tag.size() != 1 || log_tag[0] !== 11'h0AA) begin
      errors++;
      $display("FAIL rst_tu1: words=%0d required 1 with tag 0x0AA", log_tag.size());
    end
    clear_log();
    do_tick("rst_tu2");
    checks++;
    if (log_tag.size() != 2 || log_tag[0] !== 11'h0AA || log_tag[1] !== 11'h055) begin
      errors++;
      $display("FAIL rst_tu2: words=%0d required 2 with tags 0x0AA 0x055", log_tag.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_period();
    test_backpressure();
    test_prog_collision();
    test_overrun();
    test_inactive();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
